// File: rtl/branch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// branch_redirect_ctrl
//   ID-stage branch/jump sequencer for the 5-stage MIPS pipeline.
//   Stalls IF/ID while a beq/bne operand is still being produced in EX or
//   MEM, resolves beq/bne/j, and issues a one-cycle PC redirect that also
//   squashes the two wrong-path instructions. Keeps saturating counters of
//   redirects and branch stall cycles, plus a sticky over-long-stall flag.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   id_valid                 ID stage holds a valid instruction
//   id_branch/id_bne/id_jmp  beq / bne / j decode of the ID instruction
//   id_rs, id_rt             ID source register numbers
//   id_rdata1, id_rdata2     register-file read data for rs / rt
//   id_pcplus4, id_imm       PC+4 and sign-extended immediate
//   id_addr_j                26-bit jump index
//   ex_regwrite, ex_rd       EX-stage register write and destination
//   mem_regwrite, mem_rd     MEM-stage register write and destination
//   stall_if_id              hold PC and IF/ID this cycle
//   id_kill                  bubble the ID control signals into ID/EX
//   flush_if_id              clear IF/ID at the end of this cycle
//   pc_sel, pc_target        load PC from pc_target at the end of this cycle
//   taken_cnt, stall_cnt     saturating statistics counters
//   stall_err                sticky: a stall run exceeded MAX_STALL
// ---------------------------------------------------------------------------
module branch_redirect_ctrl #(
  parameter int D_WIDTH   = 32,
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic               id_branch,
  input  logic               id_bne,
  input  logic               id_jmp,
  input  logic [4:0]         id_rs,
  input  logic [4:0]         id_rt,
  input  logic [D_WIDTH-1:0] id_rdata1,
  input  logic [D_WIDTH-1:0] id_rdata2,
  input  logic [D_WIDTH-1:0] id_pcplus4,
  input  logic [D_WIDTH-1:0] id_imm,
  input  logic [25:0]        id_addr_j,
  input  logic               ex_regwrite,
  input  logic [4:0]         ex_rd,
  input  logic               mem_regwrite,
  input  logic [4:0]         mem_rd,
  output logic               stall_if_id,
  output logic               id_kill,
  output logic               flush_if_id,
  output logic               pc_sel,
  output logic [D_WIDTH-1:0] pc_target,
  output logic [CNT_W-1:0]   taken_cnt,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic               stall_err
);

  // Run counter only needs to reach MAX_STALL; the +2 keeps the width
  // non-zero for MAX_STALL=0.
  localparam int RUN_W = $clog2(MAX_STALL + 2);

  typedef enum logic [1:0] {IDLE, STALL, REDIRECT} state_t;

  state_t             state_q, state_d;
  logic [D_WIDTH-1:0] pc_target_q, pc_target_d;
  logic [CNT_W-1:0]   taken_cnt_q, taken_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic               stall_err_q, stall_err_d;

  logic               ctl, is_cond, ex_hit, mem_hit, hazard, ops_eq, taken;
  logic [D_WIDTH-1:0] br_tgt, jmp_tgt;

  always_comb begin
    ctl     = id_valid & (id_branch | id_bne | id_jmp);
    is_cond = (id_branch | id_bne) & ~id_jmp;
    ex_hit  = ex_regwrite & (ex_rd != 5'd0) & ((ex_rd == id_rs) | (ex_rd == id_rt));
    mem_hit = mem_regwrite & (mem_rd != 5'd0) & ((mem_rd == id_rs) | (mem_rd == id_rt));
    hazard  = is_cond & (ex_hit | mem_hit);
    ops_eq  = (id_rdata1 == id_rdata2);
    // id_branch together with id_bne behaves as beq.
    taken   = id_jmp | (id_branch & ops_eq) | (id_bne & ~id_branch & ~ops_eq);
    br_tgt  = id_pcplus4 + (id_imm << 2);
    jmp_tgt = {id_pcplus4[D_WIDTH-1:28], id_addr_j, 2'b00};
  end

  always_comb begin
    state_d     = state_q;
    pc_target_d = pc_target_q;
    taken_cnt_d = taken_cnt_q;
    stall_cnt_d = stall_cnt_q;
    run_d       = run_q;
    stall_err_d = stall_err_q;
    stall_if_id = 1'b0;
    id_kill     = 1'b0;
    flush_if_id = 1'b0;
    pc_sel      = 1'b0;

    case (state_q)
      IDLE, STALL: begin
        if (ctl && hazard) begin
          stall_if_id = 1'b1;
          id_kill     = 1'b1;
          state_d     = STALL;
          if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
          // This stall would make the run longer than MAX_STALL.
          if (run_q >= RUN_W'(MAX_STALL)) stall_err_d = 1'b1;
          else                            run_d       = run_q + RUN_W'(1);
        end else if (ctl) begin
          run_d = '0;
          if (taken) begin
            pc_target_d = id_jmp ? jmp_tgt : br_tgt;
            state_d     = REDIRECT;
          end else begin
            state_d = IDLE;
          end
        end else begin
          run_d   = '0;
          state_d = IDLE;
        end
      end
      REDIRECT: begin
        // ID holds a wrong-path instruction: no hazard check or resolution.
        pc_sel      = 1'b1;
        flush_if_id = 1'b1;
        id_kill     = 1'b1;
        if (taken_cnt_q != '1) taken_cnt_d = taken_cnt_q + CNT_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_target_q <= '0;
      taken_cnt_q <= '0;
      stall_cnt_q <= '0;
      run_q       <= '0;
      stall_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_target_q <= pc_target_d;
      taken_cnt_q <= taken_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      run_q       <= run_d;
      stall_err_q <= stall_err_d;
    end
  end

  assign pc_target = pc_target_q;
  assign taken_cnt = taken_cnt_q;
  assign stall_cnt = stall_cnt_q;
  assign stall_err = stall_err_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_redirect_ctrl
//   Directed bench for branch_redirect_ctrl. Each cycle the expected output
//   vector is pushed to a scoreboard queue as stimulus is applied and popped
//   and compared at the following falling edge. A second instance with
//   CNT_W=2 shares the stimulus to exercise counter saturation.
// ---------------------------------------------------------------------------
module tb_branch_redirect_ctrl;

  logic        clk, rst;
  logic        id_valid, id_branch, id_bne, id_jmp;
  logic [4:0]  id_rs, id_rt, ex_rd, mem_rd;
  logic [31:0] id_rdata1, id_rdata2, id_pcplus4, id_imm;
  logic [25:0] id_addr_j;
  logic        ex_regwrite, mem_regwrite;

  logic        stall_if_id, id_kill, flush_if_id, pc_sel, stall_err;
  logic [31:0] pc_target;
  logic [15:0] taken_cnt, stall_cnt;

  logic        s2_stall, s2_kill, s2_flush, s2_psel, s2_err;
  logic [31:0] s2_target;
  logic [1:0]  s2_taken, s2_scnt;

  branch_redirect_ctrl #(.D_WIDTH(32), .CNT_W(16), .MAX_STALL(2)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_branch(id_branch),
    .id_bne(id_bne), .id_jmp(id_jmp), .id_rs(id_rs), .id_rt(id_rt),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_pcplus4(id_pcplus4),
    .id_imm(id_imm), .id_addr_j(id_addr_j), .ex_regwrite(ex_regwrite),
    .ex_rd(ex_rd), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
    .stall_if_id(stall_if_id), .id_kill(id_kill), .flush_if_id(flush_if_id),
    .pc_sel(pc_sel), .pc_target(pc_target), .taken_cnt(taken_cnt),
    .stall_cnt(stall_cnt), .stall_err(stall_err)
  );

  branch_redirect_ctrl #(.D_WIDTH(32), .CNT_W(2), .MAX_STALL(2)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_branch(id_branch),
    .id_bne(id_bne), .id_jmp(id_jmp), .id_rs(id_rs), .id_rt(id_rt),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_pcplus4(id_pcplus4),
    .id_imm(id_imm), .id_addr_j(id_addr_j), .ex_regwrite(ex_regwrite),
    .ex_rd(ex_rd), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
    .stall_if_id(s2_stall), .id_kill(s2_kill), .flush_if_id(s2_flush),
    .pc_sel(s2_psel), .pc_target(s2_target), .taken_cnt(s2_taken),
    .stall_cnt(s2_scnt), .stall_err(s2_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall, kill, flush, psel, tchk, err;
    logic [31:0] tgt;
    logic [15:0] tcnt, scnt;
    logic [1:0]  tcnt2;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   e_tcnt = 0, e_scnt = 0;
  logic e_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Push the expected vector for the current cycle, compare at negedge,
  // then advance to just after the next rising edge.
  task automatic cyc(input logic s, input logic k, input logic f, input logic p,
                     input logic tc, input logic [31:0] t);
    exp_t e, o;
    e.stall = s; e.kill = k; e.flush = f; e.psel = p; e.tchk = tc; e.tgt = t;
    e.tcnt  = 16'(e_tcnt); e.scnt = 16'(e_scnt); e.err = e_err;
    e.tcnt2 = (e_tcnt > 3) ? 2'd3 : 2'(e_tcnt);
    sb.push_back(e);
    @(negedge clk);
    o = sb.pop_front();
    check("stall_if_id", {31'd0, stall_if_id}, {31'd0, o.stall});
    check("id_kill",     {31'd0, id_kill},     {31'd0, o.kill});
    check("flush_if_id", {31'd0, flush_if_id}, {31'd0, o.flush});
    check("pc_sel",      {31'd0, pc_sel},      {31'd0, o.psel});
    if (o.tchk) check("pc_target", pc_target, o.tgt);
    check("taken_cnt",   {16'd0, taken_cnt},   {16'd0, o.tcnt});
    check("stall_cnt",   {16'd0, stall_cnt},   {16'd0, o.scnt});
    check("stall_err",   {31'd0, stall_err},   {31'd0, o.err});
    check("taken_cnt_sat", {30'd0, s2_taken},  {30'd0, o.tcnt2});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_branch = 0; id_bne = 0; id_jmp = 0;
    id_rs = 0; id_rt = 0; id_rdata1 = 0; id_rdata2 = 0;
    id_pcplus4 = 0; id_imm = 0; id_addr_j = 0;
    ex_regwrite = 0; ex_rd = 0; mem_regwrite = 0; mem_rd = 0;
  endtask

  task automatic drv(input logic br, input logic bne, input logic jmp,
                     input logic [4:0] rs, input logic [4:0] rt,
                     input logic [31:0] d1, input logic [31:0] d2,
                     input logic [31:0] pc4, input logic [31:0] imm,
                     input logic [25:0] aj);
    id_valid = 1; id_branch = br; id_bne = bne; id_jmp = jmp;
    id_rs = rs; id_rt = rt; id_rdata1 = d1; id_rdata2 = d2;
    id_pcplus4 = pc4; id_imm = imm; id_addr_j = aj;
  endtask

  task automatic haz(input logic exw, input logic [4:0] exrd,
                     input logic memw, input logic [4:0] memrd);
    ex_regwrite = exw; ex_rd = exrd; mem_regwrite = memw; mem_rd = memrd;
  endtask

  logic [31:0] r_pc, r_imm, r_d;

  initial begin
    rst = 1'b1;
    idle();
    @(posedge clk); #1;
    cyc(0, 0, 0, 0, 1, 32'h0);              // in reset
    rst = 1'b0;
    cyc(0, 0, 0, 0, 1, 32'h0);              // reset state

    // beq taken, no hazard; wrong-path hazardous bne during REDIRECT ignored
    drv(1, 0, 0, 5'd1, 5'd2, 32'd5, 32'd5, 32'h100, 32'd3, 26'd0);
    cyc(0, 0, 0, 0, 0, 32'h0);
    drv(0, 1, 0, 5'd8, 5'd8, 32'd1, 32'd2, 32'h500, 32'd1, 26'd0);
    haz(1, 5'd8, 0, 5'd0);
    cyc(0, 1, 1, 1, 1, 32'h10C);
    e_tcnt++;
    idle();
    cyc(0, 0, 0, 0, 1, 32'h10C);

    // bne with EX then MEM hazard: two stall cycles, then redirect
    drv(0, 1, 0, 5'd8, 5'd9, 32'd1, 32'd2, 32'h200, 32'hFFFF_FFFC, 26'd0);
    haz(1, 5'd8, 0, 5'd0);
    cyc(1, 1, 0, 0, 0, 32'h0); e_scnt++;
    haz(0, 5'd0, 1, 5'd8);
    cyc(1, 1, 0, 0, 0, 32'h0); e_scnt++;
    haz(0, 5'd0, 0, 5'd0);
    cyc(0, 0, 0, 0, 0, 32'h0);
    idle();
    cyc(0, 1, 1, 1, 1, 32'h1F0); e_tcnt++;
    cyc(0, 0, 0, 0, 1, 32'h1F0);

    // j with bne also decoded and matching EX/MEM writers: jump wins, no stall
    drv(0, 1, 1, 5'd5, 5'd5, 32'd1, 32'd1, 32'hA000_0004, 32'd0, 26'h40);
    haz(1, 5'd5, 1, 5'd5);
    cyc(0, 0, 0, 0, 0, 32'h0);
    idle();
    cyc(0, 1, 1, 1, 1, 32'hA000_0100); e_tcnt++;

    // non-hazards: regwrite off, rd==0, id_valid low; not-taken cases
    drv(1, 0, 0, 5'd4, 5'd6, 32'd1, 32'd2, 32'h300, 32'd8, 26'd0);
    haz(0, 5'd4, 0, 5'd6);
    cyc(0, 0, 0, 0, 0, 32'h0);
    drv(0, 1, 0, 5'd0, 5'd0, 32'd9, 32'd9, 32'h300, 32'd8, 26'd0);
    haz(1, 5'd0, 1, 5'd0);
    cyc(0, 0, 0, 0, 0, 32'h0);
    drv(1, 1, 0, 5'd3, 5'd4, 32'd3, 32'd4, 32'h300, 32'd8, 26'd0);
    haz(0, 5'd0, 0, 5'd0);
    cyc(0, 0, 0, 0, 0, 32'h0);
    drv(1, 0, 0, 5'd3, 5'd4, 32'd3, 32'd3, 32'h300, 32'd8, 26'd0);
    id_valid = 0;
    haz(1, 5'd3, 1, 5'd4);
    cyc(0, 0, 0, 0, 1, 32'hA000_0100);
    // beq+bne with equal operands acts as beq; target wraps to 0
    drv(1, 1, 0, 5'd7, 5'd7, 32'd7, 32'd7, 32'hFFFF_FFFC, 32'd1, 26'd0);
    haz(0, 5'd0, 0, 5'd0);
    cyc(0, 0, 0, 0, 1, 32'hA000_0100);
    idle();
    cyc(0, 1, 1, 1, 1, 32'h0); e_tcnt++;

    // hazard held 3 cycles: third stall exceeds MAX_STALL, flag is sticky
    drv(0, 1, 0, 5'd3, 5'd12, 32'd1, 32'd2, 32'h400, 32'd1, 26'd0);
    haz(1, 5'd12, 0, 5'd0);
    cyc(1, 1, 0, 0, 0, 32'h0); e_scnt++;
    haz(0, 5'd0, 1, 5'd3);
    cyc(1, 1, 0, 0, 0, 32'h0); e_scnt++;
    haz(1, 5'd3, 1, 5'd12);
    cyc(1, 1, 0, 0, 0, 32'h0); e_scnt++; e_err = 1'b1;
    drv(0, 1, 0, 5'd3, 5'd12, 32'd2, 32'd2, 32'h400, 32'd1, 26'd0);
    haz(0, 5'd0, 0, 5'd0);
    cyc(0, 0, 0, 0, 0, 32'h0);
    idle();
    repeat (2) cyc(0, 0, 0, 0, 0, 32'h0);

    // rst during REDIRECT: everything back to zero, redirect dropped
    drv(1, 0, 0, 5'd1, 5'd2, 32'd4, 32'd4, 32'h1000, 32'd2, 26'd0);
    cyc(0, 0, 0, 0, 0, 32'h0);
    idle();
    rst = 1'b1;
    cyc(0, 1, 1, 1, 1, 32'h1008);
    e_tcnt = 0; e_scnt = 0; e_err = 1'b0;
    rst = 1'b0;
    cyc(0, 0, 0, 0, 1, 32'h0);
    cyc(0, 0, 0, 0, 1, 32'h0);

    // five back-to-back taken branches; CNT_W=2 instance saturates at 3
    for (int i = 0; i < 5; i++) begin
      r_pc  = $urandom;
      r_imm = $urandom;
      r_d   = $urandom;
      drv(1, 0, 0, 5'd1, 5'd2, r_d, r_d, r_pc, r_imm, 26'd0);
      cyc(0, 0, 0, 0, 0, 32'h0);
      idle();
      cyc(0, 1, 1, 1, 1, r_pc + (r_imm << 2));
      e_tcnt++;
    end
    cyc(0, 0, 0, 0, 0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
